// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM states, Morse timing constants and the code record.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, MARK, ELEM_GAP, LETTER_END} state_t;

    localparam int DOT_LEN  = 1;
    localparam int DASH_LEN = 3;
    localparam int GAP_LEN  = 1;
    localparam int END_LEN  = 2;

    // pattern is left-aligned: pattern[4] is the first element, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } code_t;

    function automatic logic [1:0] mark_len(input logic dash);
        return dash ? 2'(DASH_LEN - 1) : 2'(DOT_LEN - 1);
    endfunction

endpackage

// File: rtl/morse_if.sv
// morse_if: character handshake between a producer and the Morse transmitter.
interface morse_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/morse_rom.sv
// morse_rom: combinational ASCII to ITU Morse code lookup, lowercase folded to uppercase.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0] i_char,
    output code_t      o_code,
    output logic       o_valid
);
    logic [7:0] c;

    always_comb begin
        c = (i_char >= 8'h61 && i_char <= 8'h7a) ? i_char - 8'h20 : i_char;
        o_code = '0;
        o_valid = 1'b1;
        case (c)
            "A": o_code = {3'd2, 5'b01000};
            "B": o_code = {3'd4, 5'b10000};
            "C": o_code = {3'd4, 5'b10100};
            "D": o_code = {3'd3, 5'b10000};
            "E": o_code = {3'd1, 5'b00000};
            "F": o_code = {3'd4, 5'b00100};
            "G": o_code = {3'd3, 5'b11000};
            "H": o_code = {3'd4, 5'b00000};
            "I": o_code = {3'd2, 5'b00000};
            "J": o_code = {3'd4, 5'b01110};
            "K": o_code = {3'd3, 5'b10100};
            "L": o_code = {3'd4, 5'b01000};
            "M": o_code = {3'd2, 5'b11000};
            "N": o_code = {3'd2, 5'b10000};
            "O": o_code = {3'd3, 5'b11100};
            "P": o_code = {3'd4, 5'b01100};
            "Q": o_code = {3'd4, 5'b11010};
            "R": o_code = {3'd3, 5'b01000};
            "S": o_code = {3'd3, 5'b00000};
            "T": o_code = {3'd1, 5'b10000};
            "U": o_code = {3'd3, 5'b00100};
            "V": o_code = {3'd4, 5'b00010};
            "W": o_code = {3'd3, 5'b01100};
            "X": o_code = {3'd4, 5'b10010};
            "Y": o_code = {3'd4, 5'b10110};
            "Z": o_code = {3'd4, 5'b11000};
            "0": o_code = {3'd5, 5'b11111};
            "1": o_code = {3'd5, 5'b01111};
            "2": o_code = {3'd5, 5'b00111};
            "3": o_code = {3'd5, 5'b00011};
            "4": o_code = {3'd5, 5'b00001};
            "5": o_code = {3'd5, 5'b00000};
            "6": o_code = {3'd5, 5'b10000};
            "7": o_code = {3'd5, 5'b11000};
            "8": o_code = {3'd5, 5'b11100};
            "9": o_code = {3'd5, 5'b11110};
            8'h20: o_code = '0;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_transmitter.sv
// morse_transmitter: serialises accepted ASCII characters into an on/off Morse bit stream,
// one bit per TICK_DIV clocks, with back-to-back characters abutting seamlessly.
module morse_transmitter
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    morse_if.slave bus,
    output logic  o_data_morse,
    output logic  o_busy,
    output logic  o_err
);
    localparam logic [7:0] TICK_LOAD = 8'(TICK_DIV - 1);

    state_t     state_q;
    logic [7:0] tick_q;
    logic [1:0] len_q;
    logic [2:0] elem_q;
    logic [4:0] pat_q;
    logic       data_q;
    logic       busy_q;
    logic       err_q;
    code_t      code;
    logic       code_vld;
    logic       accept;

    morse_rom u_rom (
        .i_char (bus.i_data),
        .o_code (code),
        .o_valid(code_vld)
    );

    // ready also opens on the last clock of the letter end so the next character abuts
    assign bus.o_ready  = state_q == IDLE || (state_q == LETTER_END && len_q == 2'd0 && tick_q == 8'd0);
    assign accept       = bus.i_valid && bus.o_ready;
    assign o_data_morse = data_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            len_q   <= '0;
            elem_q  <= '0;
            pat_q   <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                tick_q <= TICK_LOAD;
                if (!code_vld) begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    len_q   <= '0;
                    elem_q  <= '0;
                    pat_q   <= '0;
                    data_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                end else if (code.len == 3'd0) begin
                    state_q <= LETTER_END;
                    len_q   <= 2'(END_LEN - 1);
                    elem_q  <= '0;
                    data_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= MARK;
                    len_q   <= mark_len(code.pattern[4]);
                    pat_q   <= {code.pattern[3:0], 1'b0};
                    elem_q  <= code.len - 3'd1;
                    data_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
            end else if (state_q != IDLE) begin
                if (tick_q != 8'd0) begin
                    tick_q <= tick_q - 8'd1;
                end else begin
                    tick_q <= TICK_LOAD;
                    if (len_q != 2'd0) begin
                        len_q <= len_q - 2'd1;
                    end else begin
                        case (state_q)
                            MARK: begin
                                state_q <= ELEM_GAP;
                                len_q   <= 2'(GAP_LEN - 1);
                                data_q  <= 1'b0;
                            end
                            ELEM_GAP: begin
                                if (elem_q != 3'd0) begin
                                    state_q <= MARK;
                                    len_q   <= mark_len(pat_q[4]);
                                    pat_q   <= {pat_q[3:0], 1'b0};
                                    elem_q  <= elem_q - 3'd1;
                                    data_q  <= 1'b1;
                                end else begin
                                    state_q <= LETTER_END;
                                    len_q   <= 2'(END_LEN - 1);
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                                tick_q  <= '0;
                                busy_q  <= 1'b0;
                                data_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_transmitter.sv
// tb_morse_transmitter: drives character streams and compares the bit stream against
// a dot/dash table model of ITU Morse.
module tb_morse_transmitter;
    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data1, busy1, err1, data3, busy3, err3;
    int   total = 0;
    int   bad = 0;

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                            "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits [10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                           "---..", "----."};

    morse_if bus1 ();
    morse_if bus3 ();

    morse_transmitter #(.TICK_DIV(1)) d1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
        .o_data_morse(data1), .o_busy(busy1), .o_err(err1)
    );
    morse_transmitter #(.TICK_DIV(3)) d3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus3),
        .o_data_morse(data3), .o_busy(busy3), .o_err(err3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic string code_of(input logic [7:0] ch, output bit ok);
        logic [7:0] u;
        u = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
        ok = 1'b1;
        if (u == 8'h20) return "";
        if (u >= 8'h41 && u <= 8'h5a) return letters[u - 8'h41];
        if (u >= 8'h30 && u <= 8'h39) return digits[u - 8'h30];
        ok = 1'b0;
        return "";
    endfunction

    function automatic bq_t expand(input string s);
        bq_t q;
        string c;
        bit ok;
        for (int i = 0; i < s.len(); i++) begin
            c = code_of(s[i], ok);
            if (!ok) continue;
            for (int j = 0; j < c.len(); j++) begin
                q.push_back(1'b1);
                if (c[j] == "-") begin
                    q.push_back(1'b1);
                    q.push_back(1'b1);
                end
                q.push_back(1'b0);
            end
            q.push_back(1'b0);
            q.push_back(1'b0);
        end
        return q;
    endfunction

    // holds i_valid with the next character until taken; records every cycle from the first accept
    task automatic run_stream(input string s, input string name);
        bq_t exp_q, obs_q;
        int idx = 0, busy_cnt = 0, cyc = 0;
        bit acc, started = 0, any_err = 0;
        exp_q = expand(s);
        while (cyc < 1000) begin
            bus1.i_valid = idx < s.len();
            bus1.i_data = bus1.i_valid ? s[idx] : 8'($urandom);
            acc = bus1.i_valid && bus1.o_ready;
            @(negedge clk);
            if (acc) begin
                started = 1;
                idx++;
            end
            any_err |= err1;
            if (started && idx == s.len() && !busy1) break;
            if (started) begin
                obs_q.push_back(data1);
                busy_cnt += busy1;
            end
            cyc++;
        end
        bus1.i_valid = 1'b0;
        total++;
        if (cyc >= 1000) begin
            bad++;
            $display("FAIL %s timeout: got %0d cycles want completion", name, cyc);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s length: got %0d bits want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s bit%0d: got %0b want %0b", name, i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (busy_cnt != exp_q.size()) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_q.size());
        end
        total++;
        if (any_err !== 1'b0) begin
            bad++;
            $display("FAIL %s err: got %0b want 0", name, any_err);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({data1, busy1, err1, bus1.o_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0001", {data1, busy1, err1, bus1.o_ready});
        end
        total++;
        if ({data3, busy3, err3, bus3.o_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_outputs_div3: got %b want 0001", {data3, busy3, err3, bus3.o_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_err();
        bus1.i_valid = 1'b1;
        bus1.i_data = "#";
        @(negedge clk);
        bus1.i_valid = 1'b0;
        bus1.i_data = "E";
        total++;
        if ({err1, data1, busy1, bus1.o_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL err_pulse: got %b want 1001", {err1, data1, busy1, bus1.o_ready});
        end
        @(negedge clk);
        total++;
        if ({err1, data1, busy1, bus1.o_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL err_after: got %b want 0001", {err1, data1, busy1, bus1.o_ready});
        end
    endtask

    task automatic test_reset_mid();
        bus1.i_valid = 1'b1;
        bus1.i_data = "K";
        @(negedge clk);
        bus1.i_valid = 1'b0;
        @(negedge clk);
        total++;
        if (data1 !== 1'b1) begin
            bad++;
            $display("FAIL k_mark: got %b want 1", data1);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({data1, busy1, err1, bus1.o_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL async_reset: got %b want 0001", {data1, busy1, err1, bus1.o_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_stream("E", "after_reset_E");
    endtask

    task automatic test_tick3();
        bq_t e;
        e = expand("e");
        bus3.i_valid = 1'b1;
        bus3.i_data = "e";
        @(negedge clk);
        bus3.i_valid = 1'b0;
        bus3.i_data = "T";
        for (int k = 0; k < 3 * e.size(); k++) begin
            total++;
            if ({data3, busy3, err3} !== {e[k / 3], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL tick3 cyc%0d: got %b want %b", k, {data3, busy3, err3}, {e[k / 3], 2'b10});
            end
            @(negedge clk);
        end
        total++;
        if ({data3, busy3, bus3.o_ready} !== 3'b001) begin
            bad++;
            $display("FAIL tick3_idle: got %b want 001", {data3, busy3, bus3.o_ready});
        end
    endtask

    task automatic test_random();
        string pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 ";
        string s;
        int k;
        for (int r = 0; r < 8; r++) begin
            s = "";
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
                k = int'($urandom_range(0, pool.len() - 1));
                s = {s, pool.substr(k, k)};
            end
            run_stream(s, $sformatf("random_%0d", r));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        bus1.i_valid = 1'b0;
        bus1.i_data = 8'h00;
        bus3.i_valid = 1'b0;
        bus3.i_data = 8'h00;
        @(negedge clk);
        test_reset();
        run_stream("T", "char_T");
        run_stream("SA", "back_to_back_SA");
        run_stream("9 ", "nine_space");
        run_stream("u", "lower_u");
        test_err();
        test_reset_mid();
        test_tick3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_transmitter.md
MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

Interface
REQ-001 Parameter TICK_DIV, default 1: clock cycles per Morse bit period; legal range 1..255.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_data  input  8  ASCII character to send.
REQ-005 i_valid  input  1  i_data valid; transfer when i_valid && o_ready at a rising edge.
REQ-006 o_ready  output  1  transmitter can accept a character this cycle.
REQ-007 o_data_morse  output  1  serial Morse bit stream, one bit per bit period.
REQ-008 o_busy  output  1  a character is being emitted.
REQ-009 o_err  output  1  one-cycle pulse: accepted character has no Morse code.

Function
REQ-010 Line encoding SHALL be as follows:
- dot = bits 1,0
- dash = bits 1,1,1,0
- letter end = 0,0 appended after the last element
- space (0x20) = 0,0 only, producing a 0000 word gap after the preceding letter end
REQ-011 Supported set SHALL be A–Z, 0–9 (standard ITU codes, 1–5 elements) and space; a–z SHALL fold to A–Z.
REQ-012 Elements SHALL be sent first-to-last in code order (e.g. 'U' = 10 10 1110 00).
REQ-013 FSM states SHALL be IDLE, MARK, ELEM_GAP and LETTER_END:
- IDLE→MARK on accept of a coded char
- IDLE→LETTER_END on accept of space
- MARK (1 or 3 periods high)→ELEM_GAP (1 period low)
- ELEM_GAP→MARK if elements remain, else →LETTER_END (2 periods low)
- LETTER_END→IDLE, or →MARK/LETTER_END directly on a back-to-back accept
REQ-014 o_ready SHALL be high in IDLE and during the final clock of the last LETTER_END period, so consecutive characters abut with no extra low bits.
REQ-015 Latency: the first bit of an accepted char SHALL appear on o_data_morse on the clock edge following acceptance.
REQ-016 o_data_morse SHALL be 0 in IDLE; o_busy SHALL be high in every non-IDLE state.
REQ-017 Each bit period SHALL last exactly TICK_DIV clocks, counted by a down-counter reloaded at every bit boundary.
REQ-018 An unsupported char SHALL be accepted, SHALL pulse o_err on the clock after acceptance, SHALL emit no bits, and SHALL leave the FSM in IDLE.
REQ-019 Counters SHALL be sized as follows and SHALL never wrap:
- element counter: 3 bits, 0..5
- mark-length counter: 2 bits
- tick counter: 8 bits
REQ-020 i_data SHALL be captured on accept; later changes to i_data SHALL NOT affect the character in flight.
REQ-021 i_valid while o_ready is low SHALL be ignored, with no queueing.

Reset
REQ-022 Asserting i_rst_n low SHALL immediately force:
- state = IDLE
- o_data_morse = 0
- o_busy = 0
- o_err = 0
- o_ready = 1
- all counters = 0
REQ-023 Reset mid-character SHALL abort the character, with no partial letter end emitted.
REQ-024 After reset release, the first accept SHALL be possible on the first rising edge.

Structure
REQ-025 Package morse_pkg SHALL hold:
- the state enum
- DOT_LEN = 1, DASH_LEN = 3, GAP_LEN = 1, END_LEN = 2
- the code typedef {len[2:0], pattern[4:0]} with bit = 1 for dash
REQ-026 Sub-module morse_rom SHALL be combinational: ASCII in → code typedef plus a valid flag out; the FSM and counters live in morse_transmitter.

Verification
REQ-027 Character 'T', TICK_DIV = 1 → o_data_morse 1,1,1,0,0,0 starting the cycle after accept; o_ready high again during the 6th bit.
REQ-028 Characters "SA" back-to-back with i_valid held → 10 10 10 00 10 1110 00, with no extra zeros between characters.
REQ-029 Character '9' followed by space → 1110×4, 10, 00, then 00; o_busy high for 22 cycles.
REQ-030 Character '#' → o_err high exactly one cycle, o_data_morse stays 0, o_ready stays high.
REQ-031 Reset asserted during 'K' MARK → o_data_morse = 0 asynchronously; next 'E' → 1,0,0,0 cleanly.
REQ-032 TICK_DIV = 3 with lowercase 'e' → o_data_morse high 3 clocks, then low 9 clocks.
